// File: rtl/mem_stage.sv
// Memory stage: drives loads/stores into a multi-cycle data memory and
// holds the pipeline until the access finishes. It also owns the MEM/WB register.
module mem_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_to_reg_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    input  logic [15:0] result_in,
    input  logic [15:0] B_in,
    input  logic [2:0]  reg_wr_sel_in,
    input  logic        dump_in,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        stall_out,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [2:0]  wb_sel,
    output logic [15:0] wb_data,
    output logic        halt_out,
    output logic        err_out
);

    typedef enum logic [1:0] {IDLE, BUSY, HALTED} state_t;

    state_t      state, state_n;
    logic [7:0]  cnt;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        acc;
    logic        unaligned;
    logic        req;
    logic        done_ok;
    logic        tmo;
    logic        alu_wb;

    assign acc       = valid_in & (mem_to_reg_in | mem_write_in);
    assign unaligned = (state == IDLE) & acc & result_in[0];
    assign req       = (state == IDLE) & acc & ~result_in[0];
    assign done_ok   = (state == BUSY) & mem_done;
    // The cycle that would bring the counter to TIMEOUT expires the access.
    assign tmo       = (state == BUSY) & ~mem_done
                     & (cnt == 8'(TIMEOUT - 1));
    assign alu_wb    = (state == IDLE) & valid_in & ~acc & ~dump_in;

    assign mem_req   = req;
    assign mem_wr    = req & mem_write_in;
    assign mem_addr  = req ? result_in : addr_q;
    assign mem_wdata = req ? B_in : wdata_q;

    assign stall_out = ((state == IDLE) & acc)
                     | ((state == BUSY) & ~mem_done)
                     | (state == HALTED);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (unaligned)
                    state_n = HALTED;
                else if (acc)
                    state_n = BUSY;
                else if (valid_in & dump_in)
                    state_n = HALTED;
            end
            BUSY: begin
                if (mem_done)
                    state_n = IDLE;
                else if (tmo)
                    state_n = HALTED;
            end
            HALTED:  state_n = HALTED;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            addr_q   <= 16'd0;
            wdata_q  <= 16'd0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_sel   <= 3'd0;
            wb_data  <= 16'd0;
            halt_out <= 1'b0;
            err_out  <= 1'b0;
        end else begin
            state    <= state_n;
            halt_out <= (state_n == HALTED);
            if (unaligned | tmo)
                err_out <= 1'b1;
            if (req) begin
                addr_q  <= result_in;
                wdata_q <= B_in;
                cnt     <= 8'd0;
            end else if (state == BUSY) begin
                cnt <= cnt + 8'd1;
            end
            // A store with the load bit also set still writes back result_in.
            if (done_ok) begin
                wb_valid <= 1'b1;
                wb_we    <= reg_write_in & ~mem_write_in;
                wb_sel   <= reg_wr_sel_in;
                wb_data  <= (mem_to_reg_in & ~mem_write_in)
                          ? mem_rdata : result_in;
            end else if (alu_wb) begin
                wb_valid <= 1'b1;
                wb_we    <= reg_write_in;
                wb_sel   <= reg_wr_sel_in;
                wb_data  <= result_in;
            end else begin
                wb_valid <= 1'b0;
                wb_we    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vectors, with the writeback results checked
// against a queue of expected entries.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_to_reg_in, mem_write_in, reg_write_in;
    logic [15:0] result_in, B_in;
    logic [2:0]  reg_wr_sel_in;
    logic        dump_in;
    logic        mem_req, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        stall_out, wb_valid, wb_we;
    logic [2:0]  wb_sel;
    logic [15:0] wb_data;
    logic        halt_out, err_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [2:0]  sel;
        logic [15:0] data;
    } wb_exp_t;

    wb_exp_t sb[$];

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .mem_to_reg_in(mem_to_reg_in),
        .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
        .result_in(result_in), .B_in(B_in),
        .reg_wr_sel_in(reg_wr_sel_in), .dump_in(dump_in),
        .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stall_out(stall_out), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_sel(wb_sel), .wb_data(wb_data),
        .halt_out(halt_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid writeback must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got sel %0d data %h, none expected",
                         wb_sel, wb_data);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                chk("wb_we", {15'd0, wb_we}, {15'd0, e.we});
                chk("wb_sel", {13'd0, wb_sel}, {13'd0, e.sel});
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        valid_in = 0; mem_to_reg_in = 0; mem_write_in = 0;
        reg_write_in = 0; dump_in = 0;
        result_in = 16'd0; B_in = 16'd0; reg_wr_sel_in = 3'd0;
    endtask

    task automatic do_reset();
        bubble();
        mem_done = 0;
        mem_rdata = 16'd0;
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_wb_valid"}, {15'd0, wb_valid}, 16'd0);
        chk({tag, "_wb_we"}, {15'd0, wb_we}, 16'd0);
        chk({tag, "_wb_sel"}, {13'd0, wb_sel}, 16'd0);
        chk({tag, "_wb_data"}, wb_data, 16'd0);
        chk({tag, "_halt"}, {15'd0, halt_out}, 16'd0);
        chk({tag, "_err"}, {15'd0, err_out}, 16'd0);
        chk({tag, "_stall"}, {15'd0, stall_out}, 16'd0);
        chk({tag, "_req"}, {15'd0, mem_req}, 16'd0);
    endtask

    // Issue one aligned memory access; mem_done arrives lat cycles after mem_req.
    task automatic mem_op(input logic ld, input logic st, input logic rw,
                          input logic [15:0] addr, input logic [15:0] bd,
                          input logic [2:0] sel, input int lat,
                          input logic [15:0] rdata,
                          input logic [15:0] exp_data, input logic exp_we);
        wb_exp_t e;
        valid_in = 1; mem_to_reg_in = ld; mem_write_in = st;
        reg_write_in = rw; dump_in = 0;
        result_in = addr; B_in = bd; reg_wr_sel_in = sel;
        e.we = exp_we; e.sel = sel; e.data = exp_data;
        sb.push_back(e);
        @(negedge clk);
        chk("req_pulse", {15'd0, mem_req}, 16'd1);
        chk("req_wr", {15'd0, mem_wr}, {15'd0, st});
        chk("req_addr", mem_addr, addr);
        if (st) chk("req_wdata", mem_wdata, bd);
        chk("req_stall", {15'd0, stall_out}, 16'd1);
        for (int i = 1; i < lat; i++) begin
            step();
            @(negedge clk);
            chk("busy_req", {15'd0, mem_req}, 16'd0);
            chk("busy_stall", {15'd0, stall_out}, 16'd1);
            chk("busy_addr", mem_addr, addr);
        end
        step();
        mem_done = 1;
        mem_rdata = rdata;
        @(negedge clk);
        chk("done_stall", {15'd0, stall_out}, 16'd0);
        chk("done_addr", mem_addr, addr);
        if (st) chk("done_wdata", mem_wdata, bd);
        step();
        mem_done = 0;
        mem_rdata = 16'd0;
        bubble();
    endtask

    initial begin
        bubble();
        mem_done = 0;
        mem_rdata = 16'd0;
        rst = 1;
        step();
        step();
        rst = 0;
        check_idle_outputs("reset");

        // ALU op
        step();
        valid_in = 1; reg_write_in = 1; result_in = 16'h1234;
        reg_wr_sel_in = 3'd5;
        sb.push_back('{we: 1'b1, sel: 3'd5, data: 16'h1234});
        @(negedge clk);
        chk("alu_stall", {15'd0, stall_out}, 16'd0);
        chk("alu_req", {15'd0, mem_req}, 16'd0);
        step();
        bubble();
        @(negedge clk);
        chk("alu_wb_valid", {15'd0, wb_valid}, 16'd1);
        chk("alu_stall2", {15'd0, stall_out}, 16'd0);
        step();

        // Load, 3-cycle memory
        mem_op(1, 0, 1, 16'h0040, 16'h0000, 3'd2, 3, 16'hBEEF, 16'hBEEF, 1);
        @(negedge clk);
        chk("ld_wb_valid", {15'd0, wb_valid}, 16'd1);
        step();

        // Store, then back-to-back load
        mem_op(0, 1, 1, 16'h0010, 16'hA5A5, 3'd3, 1, 16'h0000, 16'h0010, 0);
        mem_op(1, 0, 1, 16'h0022, 16'h0000, 3'd7, 2, 16'h5A5A, 16'h5A5A, 1);
        // Both flags set: treated as a store, writeback data is the address
        mem_op(1, 1, 1, 16'h0030, 16'h1111, 3'd4, 1, 16'hDEAD, 16'h0030, 0);
        step();

        // Unaligned load
        valid_in = 1; mem_to_reg_in = 1; reg_write_in = 1;
        result_in = 16'h0003; reg_wr_sel_in = 3'd1;
        @(negedge clk);
        chk("ua_req", {15'd0, mem_req}, 16'd0);
        chk("ua_stall", {15'd0, stall_out}, 16'd1);
        step();
        @(negedge clk);
        chk("ua_err", {15'd0, err_out}, 16'd1);
        chk("ua_halt", {15'd0, halt_out}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("ua_stall_hold", {15'd0, stall_out}, 16'd1);
            chk("ua_req_hold", {15'd0, mem_req}, 16'd0);
        end
        step();
        do_reset();
        check_idle_outputs("ua_rst");

        // Timeout: load that is never answered
        step();
        valid_in = 1; mem_to_reg_in = 1; reg_write_in = 1;
        result_in = 16'h0020; reg_wr_sel_in = 3'd6;
        @(negedge clk);
        chk("to_req", {15'd0, mem_req}, 16'd1);
        for (int c = 1; c <= 4; c++) begin
            step();
            @(negedge clk);
            chk("to_err_early", {15'd0, err_out}, 16'd0);
            chk("to_stall", {15'd0, stall_out}, 16'd1);
        end
        step();
        @(negedge clk);
        chk("to_err", {15'd0, err_out}, 16'd1);
        chk("to_halt", {15'd0, halt_out}, 16'd1);
        chk("to_stall_halt", {15'd0, stall_out}, 16'd1);
        step();
        do_reset();
        check_idle_outputs("to_rst");

        // Dump on a non-memory instruction
        step();
        valid_in = 1; dump_in = 1; reg_write_in = 1;
        result_in = 16'h7777; reg_wr_sel_in = 3'd2;
        @(negedge clk);
        chk("dump_stall", {15'd0, stall_out}, 16'd0);
        step();
        @(negedge clk);
        chk("dump_halt", {15'd0, halt_out}, 16'd1);
        chk("dump_wb_valid", {15'd0, wb_valid}, 16'd0);
        chk("dump_stall_h", {15'd0, stall_out}, 16'd1);
        step();
        do_reset();
        check_idle_outputs("dump_rst");

        // Reset in the middle of an access, then a late mem_done
        step();
        valid_in = 1; mem_to_reg_in = 1; reg_write_in = 1;
        result_in = 16'h0050; reg_wr_sel_in = 3'd3;
        @(negedge clk);
        chk("mid_req", {15'd0, mem_req}, 16'd1);
        step();
        do_reset();
        mem_done = 1;
        mem_rdata = 16'hCAFE;
        @(negedge clk);
        chk("late_stall", {15'd0, stall_out}, 16'd0);
        step();
        mem_done = 0;
        mem_rdata = 16'd0;
        @(negedge clk);
        chk("late_wb_valid", {15'd0, wb_valid}, 16'd0);
        chk("late_halt", {15'd0, halt_out}, 16'd0);

        // ALU op still works after the aborted access
        step();
        valid_in = 1; reg_write_in = 0; result_in = 16'h00FF;
        reg_wr_sel_in = 3'd1;
        sb.push_back('{we: 1'b0, sel: 3'd1, data: 16'h00FF});
        step();
        bubble();
        step();
        step();
        @(negedge clk);
        chk("sb_drained", 16'(sb.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
